// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT helpers: log2, width-parameterized bitrev, complex sample type
package fft_pkg;

    localparam int FFT_WIDTH = 16;

    typedef struct packed {
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
    } cplx_t;

    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[w-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// rtl/reorder_ram.sv - dual-bank sample store, one write port and one synchronous read port
module reorder_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - bit-reversed to natural order ping-pong frame reorder buffer
// Optional do_idx output enabled by defining FFT_REORDER_IDX_EN.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = 128,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
`ifdef FFT_REORDER_IDX_EN
    ,
    output logic [log2(N)-1:0] do_idx
`endif
);

    localparam int LOGN = log2(N);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state, state_nxt;
    logic [LOGN-1:0]    wcnt;
    logic [LOGN-1:0]    rcnt, rcnt_nxt;
    logic               wbank;
    logic               rd_req;
    logic               rd_en;
    logic               rd_vld;
    logic [LOGN:0]      waddr;
    logic [LOGN:0]      raddr;
    logic [2*WIDTH-1:0] rdata;

    assign rd_req = di_en && (wcnt == LAST);
    assign rd_en  = (state == READ);
    assign waddr  = {wbank, LOGN'(bitrev(32'(wcnt), LOGN))};
    assign raddr  = {~wbank, rcnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (di_en) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == LAST) wbank <= ~wbank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // A request landing on the last read address chains straight into the next frame.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_nxt = READ;
                    rcnt_nxt  = '0;
                end
            end
            READ: begin
                if (rcnt == LAST) begin
                    rcnt_nxt = '0;
                    if (!rd_req) state_nxt = IDLE;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    reorder_ram #(
        .AW (LOGN + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (di_en),
        .waddr (waddr),
        .wdata ({di_re, di_im}),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
        end else begin
            rd_vld <= rd_en;
            do_en  <= rd_vld;
            if (rd_vld) begin
                do_re <= rdata[2*WIDTH-1:WIDTH];
                do_im <= rdata[WIDTH-1:0];
            end
        end
    end

`ifdef FFT_REORDER_IDX_EN
    logic [LOGN-1:0] rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= '0;
            do_idx <= '0;
        end else begin
            if (rd_en) rd_idx <= rcnt;
            if (rd_vld) do_idx <= rd_idx;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - scoreboard bench for fft_bitrev_reorder at N=8 and N=128
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int W = 16;

    typedef struct {
        longint cyc;
        cplx_t  d;
        int     idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en  [2];
    logic [W-1:0] dre [2];
    logic [W-1:0] dim [2];
    logic         oen [2];
    logic [W-1:0] ore [2];
    logic [W-1:0] oim [2];
    int           gidx0, gidx1;
`ifdef FFT_REORDER_IDX_EN
    logic [2:0]   oidx8;
    logic [6:0]   oidx128;
    assign gidx0 = int'(oidx8);
    assign gidx1 = int'(oidx128);
`else
    assign gidx0 = -1;
    assign gidx1 = -1;
`endif

    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   q0[$];
    exp_t   q1[$];
    cplx_t  frm [2][128];
    int     k [2];

    fft_bitrev_reorder #(.N(8), .WIDTH(W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .di_en(en[0]), .di_re(dre[0]), .di_im(dim[0]),
        .do_en(oen[0]), .do_re(ore[0]), .do_im(oim[0])
`ifdef FFT_REORDER_IDX_EN
        , .do_idx(oidx8)
`endif
    );

    fft_bitrev_reorder #(.N(128), .WIDTH(W)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .di_en(en[1]), .di_re(dre[1]), .di_im(dim[1]),
        .do_en(oen[1]), .do_re(ore[1]), .do_im(oim[1])
`ifdef FFT_REORDER_IDX_EN
        , .do_idx(oidx128)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nsz(input int d);
        return (d == 0) ? 8 : 128;
    endfunction

    function automatic int brev(input int v, input int b);
        int r;
        r = 0;
        for (int i = 0; i < b; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic mon(input int d, input logic e, input cplx_t got, input int gidx);
        exp_t x;
        int   qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (!rst_n) begin
            n_cmp++;
            if (e !== 1'b0 || got !== '0) begin
                n_bad++;
                $display("FAIL reset_out dut%0d: got en=%b data=%h, required en=0 data=0", d, e, got);
            end
        end else if (e === 1'b1) begin
            n_cmp++;
            if (qs == 0) begin
                n_bad++;
                $display("FAIL spurious dut%0d cyc=%0d: got data=%h with nothing expected", d, cyc, got);
            end else begin
                if (d == 0) x = q0.pop_front();
                else        x = q1.pop_front();
                if (x.cyc != cyc || got !== x.d || (gidx >= 0 && gidx != x.idx)) begin
                    n_bad++;
                    $display("FAIL out dut%0d: got cyc=%0d data=%h idx=%0d, required cyc=%0d data=%h idx=%0d",
                             d, cyc, got, gidx, x.cyc, x.d, x.idx);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, oen[0], {ore[0], oim[0]}, gidx0);
        mon(1, oen[1], {ore[1], oim[1]}, gidx1);
    end

    // Natural bin j of a frame is whichever sample arrived at position bitrev(j).
    task automatic send(input int d, input logic [W-1:0] r, input logic [W-1:0] i, input int gap);
        exp_t x;
        int   n;
        int   lg;
        repeat (gap) begin
            @(negedge clk);
            en[d] = 1'b0;
            dre[d] = W'($urandom);
            dim[d] = W'($urandom);
        end
        @(negedge clk);
        en[d] = 1'b1;
        dre[d] = r;
        dim[d] = i;
        frm[d][k[d]] = '{re: r, im: i};
        k[d]++;
        n = nsz(d);
        lg = (d == 0) ? 3 : 7;
        if (k[d] == n) begin
            k[d] = 0;
            for (int j = 0; j < n; j++) begin
                x.cyc = cyc + 3 + j;
                x.d   = frm[d][brev(j, lg)];
                x.idx = j;
                if (d == 0) q0.push_back(x);
                else        q1.push_back(x);
            end
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        en[d] = 1'b0;
        dre[d] = W'($urandom);
        dim[d] = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d outputs pending, required 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        k[0] = 0;
        k[1] = 0;
        q0.delete();
        q1.delete();
        #1;
        n_cmp++;
        if (oen[0] !== 1'b0 || oen[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got do_en=%b/%b, required 0/0", oen[0], oen[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_en(input int d);
        int t;
        t = 0;
        while (oen[d] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (oen[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_en dut%0d: got do_en=%b after %0d cycles, required 1", d, oen[d], t);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0;
            dre[d] = '0;
            dim[d] = '0;
            k[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) send(0, W'(i), W'(-i), 0);
        idle(0);
        drain();

        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 128; i++) send(1, W'(1000 * f + i), W'($urandom), 0);
        idle(1);
        drain();

        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) send(0, W'($urandom), W'($urandom), $urandom_range(1, 3));
        idle(0);
        drain();

        for (int i = 0; i < 5; i++) send(0, W'($urandom), W'($urandom), 0);
        rst_pulse();
        for (int i = 0; i < 8; i++) send(0, W'(100 + i), W'($urandom), 0);
        idle(0);
        drain();

        for (int i = 0; i < 8; i++) send(0, W'($urandom), W'($urandom), 0);
        idle(0);
        wait_en(0);
        rst_pulse();
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) send(0, W'($urandom), W'($urandom), 0);
        idle(0);
        drain();

        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 8; i++) send(0, W'($urandom), W'($urandom), $urandom_range(0, 2));
        idle(0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
